// File: rtl/msnw2axi_wr_engine.sv
// ---------------------------------------------------------------------------
// msnw2axi_wr_engine
// AXI3 write master for the msnw2axi path. It takes one burst request at a
// time from the msnw core and issues it on AW. It then passes the msnw write
// beats through to W. B responses are returned to the msnw side as one-cycle
// rsp pulses. Up to MAX_OUTST bursts may be waiting for their B response.
// Each accepted burst takes the next ID from a rotating counter.
//
// Handshake rule used on every channel: a transfer happens on the rising
// clk edge where valid and ready are both high. Once valid is raised, it
// stays high and the payload stays stable until that edge.
//
// Ports
//   clk, rstb          clock, synchronous active-high reset
//   req_*              burst request stream (start address, beats-1)
//   wr_*               write-beat stream, passed through to W while in DATA
//   rsp_*              completed-burst report (ID, response), one pulse each
//   m_aw*              AXI write-address channel, including byte parity
//   m_w*               AXI write-data channel, including per-byte parity
//   m_b*               AXI write-response channel
//   dbg_state_o        FSM state: 0 = IDLE, 1 = ADDR, 2 = DATA
// ---------------------------------------------------------------------------
module msnw2axi_wr_engine #(
    parameter int  DATA_W    = 64,
    parameter int  ID_W      = 9,
    parameter int  MAX_OUTST = 4,
    localparam int BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_strb,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [1:0]        rsp_resp,
    output logic [31:0]       m_awaddr,
    output logic [3:0]        m_awaddr_parity,
    output logic [1:0]        m_awburst,
    output logic [ID_W-1:0]   m_awid,
    output logic [3:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [BE_W-1:0]   m_wdata_ecc,
    output logic [ID_W-1:0]   m_wid,
    output logic              m_wlast,
    output logic [BE_W-1:0]   m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [ID_W-1:0]   m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [1:0]        dbg_state_o
);

    localparam logic [2:0]  AWSIZE    = 3'($clog2(BE_W));
    localparam logic [31:0] ADDR_MASK = ~32'(BE_W - 1);
    localparam logic [3:0]  OUTST_MAX = 4'(MAX_OUTST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_cnt_q, id_cnt_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic [3:0]        awlen_q, awlen_d;
    logic [ID_W-1:0]   awid_q, awid_d;
    // Set by the first accepted request. It keeps awsize/awburst at 0 from
    // reset until then.
    logic              aw_cfg_q, aw_cfg_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        outst_q, outst_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;

    logic req_hs, aw_hs, w_hs, b_hs, b_dec;

    assign req_hs = req_valid && req_ready;
    assign aw_hs  = m_awvalid && m_awready;
    assign w_hs   = m_wvalid && m_wready;
    assign b_hs   = m_bvalid && m_bready;
    // A B response that arrives with nothing outstanding must not wrap the counter.
    assign b_dec  = b_hs && (outst_q != 4'd0);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rstb) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = ADDR;
            ADDR:    if (aw_hs) state_d = DATA;
            DATA:    if (w_hs && m_wlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. W is a pure pass-through, gated to zero outside DATA.
    always_comb begin
        req_ready = (state_q == IDLE) && (outst_q < OUTST_MAX) && !rstb;
        m_awvalid = (state_q == ADDR);
        m_wvalid  = (state_q == DATA) && wr_valid;
        wr_ready  = (state_q == DATA) && m_wready;
        m_wdata   = (state_q == DATA) ? wr_data : '0;
        m_wstrb   = (state_q == DATA) ? wr_strb : '0;
        m_wlast   = (state_q == DATA) && (beat_q == awlen_q);
        m_bready  = !rstb;
    end

    // Datapath next-state
    always_comb begin
        id_cnt_d    = id_cnt_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awid_d      = awid_q;
        aw_cfg_d    = aw_cfg_q;
        beat_d      = beat_q;
        outst_d     = outst_q;
        rsp_valid_d = b_hs;
        rsp_id_d    = rsp_id_q;
        rsp_resp_d  = rsp_resp_q;

        if (req_hs) begin
            awaddr_d = req_addr & ADDR_MASK;
            awlen_d  = req_len;
            awid_d   = id_cnt_q;
            aw_cfg_d = 1'b1;
            id_cnt_d = id_cnt_q + 1'b1;
        end

        if (aw_hs)     beat_d = 4'd0;
        else if (w_hs) beat_d = beat_q + 4'd1;

        case ({aw_hs, b_dec})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase

        if (b_hs) begin
            rsp_id_d   = m_bid;
            rsp_resp_d = m_bresp;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            id_cnt_q    <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awid_q      <= '0;
            aw_cfg_q    <= 1'b0;
            beat_q      <= '0;
            outst_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_resp_q  <= '0;
        end else begin
            id_cnt_q    <= id_cnt_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awid_q      <= awid_d;
            aw_cfg_q    <= aw_cfg_d;
            beat_q      <= beat_d;
            outst_q     <= outst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Even parity per byte for the address and the data.
    always_comb begin
        m_awaddr_parity = '0;
        m_wdata_ecc     = '0;
        for (int i = 0; i < 4; i++)    m_awaddr_parity[i] = ^awaddr_q[8*i +: 8];
        for (int i = 0; i < BE_W; i++) m_wdata_ecc[i]     = ^m_wdata[8*i +: 8];
    end

    assign m_awaddr    = awaddr_q;
    assign m_awlen     = awlen_q;
    assign m_awid      = awid_q;
    assign m_awsize    = aw_cfg_q ? AWSIZE : 3'd0;
    assign m_awburst   = aw_cfg_q ? 2'b01 : 2'b00;
    assign m_wid       = awid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_resp    = rsp_resp_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_msnw2axi_wr_engine.sv
module tb_msnw2axi_wr_engine;

  localparam int DATA_W    = 64;
  localparam int ID_W      = 9;
  localparam int MAX_OUTST = 4;
  localparam int BE_W      = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic              req_valid, req_ready;
  logic [31:0]       req_addr;
  logic [3:0]        req_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_strb;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [1:0]        rsp_resp;
  logic [31:0]       m_awaddr;
  logic [3:0]        m_awaddr_parity;
  logic [1:0]        m_awburst;
  logic [ID_W-1:0]   m_awid;
  logic [3:0]        m_awlen;
  logic [2:0]        m_awsize;
  logic              m_awvalid, m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_wdata_ecc;
  logic [ID_W-1:0]   m_wid;
  logic              m_wlast;
  logic [BE_W-1:0]   m_wstrb;
  logic              m_wvalid, m_wready;
  logic [ID_W-1:0]   m_bid;
  logic [1:0]        m_bresp;
  logic              m_bvalid, m_bready;
  logic [1:0]        dbg_state_o;

  msnw2axi_wr_engine #(.DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awaddr_parity(m_awaddr_parity), .m_awburst(m_awburst),
    .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wdata_ecc(m_wdata_ecc), .m_wid(m_wid), .m_wlast(m_wlast),
    .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- reference model state ----------------
  int                vectors = 0;
  int                miscompares = 0;
  int                exp_outst;
  logic [ID_W-1:0]   exp_id;
  logic [ID_W-1:0]   cur_id;
  logic [31:0]       cur_addr;
  logic [3:0]        cur_len;
  logic [DATA_W-1:0] beat_data [16];
  logic [BE_W-1:0]   beat_strb [16];

  function automatic logic [3:0] addr_par(input logic [31:0] a);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ($countones(a[8*i +: 8]) % 2) == 1;
    return p;
  endfunction

  function automatic logic [BE_W-1:0] data_par(input logic [DATA_W-1:0] d);
    logic [BE_W-1:0] p;
    for (int i = 0; i < BE_W; i++) p[i] = ($countones(d[8*i +: 8]) % 2) == 1;
    return p;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      beat_data[i] = {$urandom, $urandom};
      beat_strb[i] = BE_W'($urandom);
    end
  endtask

  task automatic chk_aw(input string tag);
    chk({tag, "_awvalid"}, m_awvalid, 1'b1);
    chk({tag, "_awaddr"}, m_awaddr, (cur_addr / BE_W) * BE_W);
    chk({tag, "_awlen"}, m_awlen, cur_len);
    chk({tag, "_awsize"}, m_awsize, $clog2(BE_W));
    chk({tag, "_awburst"}, m_awburst, 2'b01);
    chk({tag, "_awid"}, m_awid, cur_id);
    chk({tag, "_awparity"}, m_awaddr_parity, addr_par((cur_addr / BE_W) * BE_W));
  endtask

  task automatic chk_ready(input string tag);
    chk(tag, req_ready, exp_outst < MAX_OUTST);
  endtask

  // Request, AW stall for 'stall' cycles, AW handshake (optionally with a B in the same cycle).
  task automatic start_burst(input logic [31:0] addr, input logic [3:0] len, input int stall,
                             input bit with_b, input logic [ID_W-1:0] bid, input logic [1:0] bresp);
    int n = 0;
    int pre;
    while (!req_ready && n < 100) begin step(); n++; end
    chk("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = addr; req_len = len;
    #1;
    chk("awvalid_before_accept", m_awvalid, 1'b0);
    step();
    req_valid = 1'b0;
    cur_id = exp_id; exp_id = exp_id + 1'b1; cur_addr = addr; cur_len = len;
    #1;
    chk_aw("aw_first");
    wr_valid = 1'b1; m_wready = 1'b1;
    for (int s = 0; s < stall; s++) begin
      step();
      chk_aw("aw_stall");
      chk("wvalid_in_addr", m_wvalid, 1'b0);
      chk("wr_ready_in_addr", wr_ready, 1'b0);
    end
    m_awready = 1'b1;
    if (with_b) begin m_bvalid = 1'b1; m_bid = bid; m_bresp = bresp; end
    step();
    m_awready = 1'b0; m_bvalid = 1'b0; wr_valid = 1'b0;
    pre = exp_outst;
    exp_outst++;
    if (with_b && pre > 0) exp_outst--;
    if (with_b) begin
      chk("rsp_valid_aw_b", rsp_valid, 1'b1);
      chk("rsp_id_aw_b", rsp_id, bid);
      chk("rsp_resp_aw_b", rsp_resp, bresp);
    end
  endtask

  task automatic send_beats(input int nbeats, input bit toggle);
    int b = 0;
    int guard = 0;
    while (b < nbeats && guard < 200) begin
      wr_valid = 1'b1; wr_data = beat_data[b]; wr_strb = beat_strb[b];
      m_wready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("wvalid", m_wvalid, 1'b1);
      chk("wdata", m_wdata, beat_data[b]);
      chk("wstrb", m_wstrb, beat_strb[b]);
      chk("wr_ready_mirror", wr_ready, m_wready);
      chk("wlast", m_wlast, b == int'(cur_len));
      chk("wid", m_wid, cur_id);
      chk("wdata_ecc", m_wdata_ecc, data_par(beat_data[b]));
      if (m_wready) b++;
      step();
      guard++;
    end
    chk("beats_bound", b, nbeats);
    wr_valid = 1'b0; m_wready = 1'b1;
  endtask

  task automatic burst(input logic [31:0] addr, input logic [3:0] len, input int stall, input bit toggle);
    start_burst(addr, len, stall, 1'b0, '0, 2'b00);
    send_beats(int'(len) + 1, toggle);
    wr_valid = 1'b1;
    #1;
    chk("wvalid_after_burst", m_wvalid, 1'b0);
    wr_valid = 1'b0;
  endtask

  task automatic send_b(input logic [ID_W-1:0] bid, input logic [1:0] bresp);
    m_bvalid = 1'b1; m_bid = bid; m_bresp = bresp;
    step();
    m_bvalid = 1'b0;
    if (exp_outst > 0) exp_outst--;
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, bid);
    chk("rsp_resp", rsp_resp, bresp);
    chk_ready("req_ready_after_b");
    step();
    chk("rsp_valid_pulse_end", rsp_valid, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_awvalid"}, m_awvalid, 1'b0);
    chk({tag, "_awaddr"}, m_awaddr, 32'd0);
    chk({tag, "_awparity"}, m_awaddr_parity, 4'd0);
    chk({tag, "_awid"}, m_awid, '0);
    chk({tag, "_awlen"}, m_awlen, 4'd0);
    chk({tag, "_awsize"}, m_awsize, 3'd0);
    chk({tag, "_awburst"}, m_awburst, 2'd0);
    chk({tag, "_wvalid"}, m_wvalid, 1'b0);
    chk({tag, "_wr_ready"}, wr_ready, 1'b0);
    chk({tag, "_wdata"}, m_wdata, '0);
    chk({tag, "_wstrb"}, m_wstrb, '0);
    chk({tag, "_wecc"}, m_wdata_ecc, '0);
    chk({tag, "_wlast"}, m_wlast, 1'b0);
    chk({tag, "_wid"}, m_wid, '0);
    chk({tag, "_bready"}, m_bready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_id"}, rsp_id, '0);
    chk({tag, "_rsp_resp"}, rsp_resp, 2'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rstb = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b1; wr_data = {$urandom, $urandom}; wr_strb = '1;
    m_awready = 1'b0; m_wready = 1'b1; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    exp_outst = 0; exp_id = '0;
    repeat (3) step();
    chk_reset_outputs("reset");
    rstb = 1'b0; wr_valid = 1'b0;
    #1;
    chk("bready_out_of_reset", m_bready, 1'b1);
    chk("req_ready_out_of_reset", req_ready, 1'b1);

    // 4-beat burst at an unaligned address, with directed parity data.
    fill_rand();
    beat_data[0] = 64'h0000_0000_0000_0103;
    beat_data[1] = 64'h0000_0000_0000_00FF;
    burst(32'h0000_1007, 4'd3, 0, 1'b0);
    send_b(cur_id, 2'b00);

    // AW held off for 6 cycles, W ready toggling.
    fill_rand();
    burst($urandom, 4'd2, 6, 1'b1);
    send_b(cur_id, 2'b01);

    // Fill the outstanding window with single-beat bursts.
    for (int k = 0; k < MAX_OUTST; k++) begin
      fill_rand();
      burst($urandom, 4'd0, $urandom_range(0, 2), 1'b0);
    end
    chk_ready("req_ready_window_full");
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("awvalid_blocked", m_awvalid, 1'b0);
    end
    req_valid = 1'b0;
    send_b(9'd2, 2'b10);

    // Next burst, with a B arriving in the same cycle as its AW handshake.
    fill_rand();
    start_burst($urandom, 4'd1, $urandom_range(0, 2), 1'b1, 9'd3, 2'b00);
    send_beats(2, 1'b1);
    chk_ready("req_ready_after_aw_b");

    // Drain, then one stray B with nothing outstanding.
    while (exp_outst > 0) send_b(ID_W'($urandom), 2'($urandom));
    send_b(ID_W'($urandom), 2'b11);
    for (int k = 0; k < MAX_OUTST; k++) begin
      fill_rand();
      burst($urandom, 4'($urandom_range(0, 3)), 0, 1'b1);
    end
    chk_ready("req_ready_refill_full");
    while (exp_outst > 0) send_b(ID_W'($urandom), 2'($urandom));

    // Reset in the middle of a 4-beat burst.
    fill_rand();
    start_burst($urandom, 4'd3, 0, 1'b0, '0, 2'b00);
    send_beats(2, 1'b0);
    wr_valid = 1'b1; wr_data = {$urandom, $urandom}; wr_strb = '1;
    rstb = 1'b1;
    step();
    chk_reset_outputs("mid_burst_reset");
    rstb = 1'b0; wr_valid = 1'b0;
    exp_id = '0; exp_outst = 0;
    fill_rand();
    burst($urandom, 4'd1, 1, 1'b1);
    chk("awid_after_reset", cur_id, 9'd0);
    send_b(cur_id, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
